// File: rtl/fp4_mac_seq_if.sv
// Job, operand and result handshakes between the operand buffers and fp4_mac_seq.
// master drives jobs/operands and consumes results; slave is the sequencer.
interface fp4_mac_seq_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] start_len;
  logic             start_ready;

  logic             in_valid;
  logic [3:0]       in_a0;
  logic [3:0]       in_b0;
  logic [3:0]       in_a1;
  logic [3:0]       in_b1;
  logic             in_ready;

  logic             res_valid;
  logic [3:0]       res0;
  logic [3:0]       res1;
  logic             res_ready;

  modport master (
    output start, start_len, in_valid, in_a0, in_b0, in_a1, in_b1, res_ready,
    input  start_ready, in_ready, res_valid, res0, res1
  );

  modport slave (
    input  start, start_len, in_valid, in_a0, in_b0, in_a1, in_b1, res_ready,
    output start_ready, in_ready, res_valid, res0, res1
  );
endinterface

// File: rtl/fp4_mac_seq.sv
// Job sequencer for the two-lane FP4 MAC: clears the MAC, streams a job's operands,
// drains the MAC pipeline with zeros, then holds both lane results until consumed.
module fp4_mac_seq #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  fp4_mac_seq_if.slave bus,
  output logic [3:0] mac_a0,
  output logic [3:0] mac_b0,
  output logic [3:0] mac_a1,
  output logic [3:0] mac_b1,
  output logic       mac_clr,
  input  logic [3:0] facc0,
  input  logic [3:0] facc1,
  output logic       busy
);

  localparam int LAT_W = $clog2(MAC_LAT + 2);
  localparam int CNT_W = (LEN_W > LAT_W) ? LEN_W : LAT_W;
  // The operand register adds one cycle in front of the MAC's own latency.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAC_LAT);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             in_fire;
  logic             capture;
  logic             res_valid_q;
  logic [3:0]       res0_q, res1_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    in_fire = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: state_d = (len_q != '0) ? RUN : DRAIN;
      RUN: begin
        if (bus.in_valid) begin
          in_fire = 1'b1;
          if (cnt + CNT_W'(1) == CNT_W'(len_q)) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          capture = 1'b1;
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (res_valid_q && bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      cnt         <= '0;
      mac_clr     <= 1'b1;
      mac_a0      <= '0;
      mac_b0      <= '0;
      mac_a1      <= '0;
      mac_b1      <= '0;
      res0_q      <= '0;
      res1_q      <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && bus.start) len_q <= bus.start_len;
      mac_clr <= (state == CLEAR);
      // Idle operand slots feed zeros, which leave the accumulators untouched.
      mac_a0  <= in_fire ? bus.in_a0 : 4'b0000;
      mac_b0  <= in_fire ? bus.in_b0 : 4'b0000;
      mac_a1  <= in_fire ? bus.in_a1 : 4'b0000;
      mac_b1  <= in_fire ? bus.in_b1 : 4'b0000;
      if (capture) begin
        res0_q <= facc0;
        res1_q <= facc1;
      end
      res_valid_q <= (state == DONE) && !(res_valid_q && bus.res_ready);
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.in_ready    = (state == RUN);
  assign bus.res_valid   = res_valid_q;
  assign bus.res0        = res0_q;
  assign bus.res1        = res1_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_fp4_mac_seq.sv
// Directed bench for fp4_mac_seq with a behavioural FP4 MAC and a result scoreboard.
module tb_fp4_mac_seq;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mac_a0, mac_b0, mac_a1, mac_b1;
  logic       mac_clr;
  logic [3:0] facc0, facc1;
  logic       busy;

  always #5 clk = ~clk;

  fp4_mac_seq_if #(.LEN_W(LEN_W)) bus ();

  fp4_mac_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mac_a0  (mac_a0),
    .mac_b0  (mac_b0),
    .mac_a1  (mac_a1),
    .mac_b1  (mac_b1),
    .mac_clr (mac_clr),
    .facc0   (facc0),
    .facc1   (facc1),
    .busy    (busy)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  bit         rv_q = 1'b0;

  function automatic real fp4_val(input logic [3:0] c);
    real m;
    case (c[2:0])
      3'd0: m = 0.0;
      3'd1: m = 0.5;
      3'd2: m = 1.0;
      3'd3: m = 1.5;
      3'd4: m = 2.0;
      3'd5: m = 3.0;
      3'd6: m = 4.0;
      default: m = 6.0;
    endcase
    return c[3] ? -m : m;
  endfunction

  function automatic logic [3:0] fp4_enc(input real v);
    logic [3:0] best = 4'b0000;
    real        bd = 1.0e9;
    real        d;
    for (int i = 0; i < 16; i++) begin
      d = fp4_val(4'(i)) - v;
      if (d < 0.0) d = -d;
      if (d < bd) begin
        bd   = d;
        best = 4'(i);
      end
    end
    return best;
  endfunction

  // Behavioural MAC: product stage, accumulate stage, encoded output stage.
  real p0 = 0.0, p1 = 0.0, acc0 = 0.0, acc1 = 0.0;
  always @(posedge clk) begin
    if (mac_clr) begin
      p0 <= 0.0; p1 <= 0.0; acc0 <= 0.0; acc1 <= 0.0;
      facc0 <= 4'b0000; facc1 <= 4'b0000;
    end else begin
      p0    <= fp4_val(mac_a0) * fp4_val(mac_b0);
      p1    <= fp4_val(mac_a1) * fp4_val(mac_b1);
      acc0  <= acc0 + p0;
      acc1  <= acc1 + p1;
      facc0 <= fp4_enc(acc0);
      facc1 <= fp4_enc(acc1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each new result is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (bus.res_valid && !rv_q) begin
      if (sb.size() == 0) begin
        check("unexpected result", 32'(bus.res_valid), 32'(0));
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("result res0,res1", 32'({bus.res0, bus.res1}), 32'(e));
      end
    end
    rv_q = bus.res_valid;
  end

  task automatic run_job(input string name, input int len, input logic [15:0] vpat,
                         input logic [3:0] a0, input logic [3:0] b0,
                         input logic [3:0] a1, input logic [3:0] b1,
                         input logic [3:0] e0, input logic [3:0] e1,
                         input int exp_lat, input int hold, input bit poke);
    int cyc = 0;
    int hs = 0;
    int pidx = 0;
    bit prev_fire = 1'b0;
    bit fire;
    check({name, " start_ready"}, 32'(bus.start_ready), 32'(1));
    sb.push_back({e0, e1});
    bus.start = 1'b1; bus.start_len = LEN_W'(len);
    bus.in_valid = 1'b1;
    bus.in_a0 = a0; bus.in_b0 = b0; bus.in_a1 = a1; bus.in_b1 = b1;
    @(negedge clk);
    bus.start = poke; bus.start_len = 8'd5;
    while (!bus.res_valid && cyc < 100) begin
      check({name, " mac_ops"}, 32'({mac_a0, mac_b0, mac_a1, mac_b1}),
            prev_fire ? 32'({a0, b0, a1, b1}) : 32'(0));
      check({name, " mac_clr"}, 32'(mac_clr), 32'(cyc == 1));
      if (bus.in_ready) begin
        bus.in_valid = (pidx < 16) ? vpat[pidx] : 1'b1;
        pidx++;
      end else begin
        bus.in_valid = 1'b1;
      end
      fire = bus.in_ready && bus.in_valid;
      hs += int'(fire);
      prev_fire = fire;
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    check({name, " handshakes"}, 32'(hs), 32'(len));
    for (int i = 0; i < hold; i++) begin
      check({name, " hold valid"}, 32'(bus.res_valid), 32'(1));
      check({name, " hold data"}, 32'({bus.res0, bus.res1}), 32'({e0, e1}));
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
    check({name, " res_valid drop"}, 32'(bus.res_valid), 32'(0));
    check({name, " back to idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.start_len = '0; bus.in_valid = 1'b0;
    bus.in_a0 = '0; bus.in_b0 = '0; bus.in_a1 = '0; bus.in_b1 = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset mac_clr", 32'(mac_clr), 32'(1));
    check("reset start_ready", 32'(bus.start_ready), 32'(1));
    check("reset in_ready", 32'(bus.in_ready), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset res_valid", 32'(bus.res_valid), 32'(0));
    check("reset res", 32'({bus.res0, bus.res1}), 32'(0));
    check("reset mac_ops", 32'({mac_a0, mac_b0, mac_a1, mac_b1}), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("mac_clr after reset", 32'(mac_clr), 32'(0));

    run_job("len1", 1, 16'hFFFF, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
            4'b0010, 4'b0000, 7, 0, 1'b0);
    run_job("len2", 2, 16'hFFFF, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
            4'b0100, 4'b0100, 8, 0, 1'b0);
    run_job("len3", 3, 16'hFFFF, 4'b0010, 4'b0010, 4'b0001, 4'b0100,
            4'b0101, 4'b0101, 9, 0, 1'b0);
    // Valid pattern 1,0,0,1,0,1 (LSB first), then held high.
    run_job("len3 gaps", 3, 16'hFFE9, 4'b0010, 4'b0010, 4'b0001, 4'b0100,
            4'b0101, 4'b0101, 12, 0, 1'b0);
    run_job("len2 signed", 2, 16'hFFFF, 4'b0011, 4'b0100, 4'b1010, 4'b0010,
            4'b0111, 4'b1100, 8, 0, 1'b0);
    run_job("len0 poke", 0, 16'hFFFF, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
            4'b0000, 4'b0000, 6, 0, 1'b1);
    run_job("hold10", 1, 16'hFFFF, 4'b0101, 4'b0100, 4'b0110, 4'b0001,
            4'b0111, 4'b0100, 7, 10, 1'b0);
    run_job("back2back", 1, 16'hFFFF, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
            4'b0010, 4'b0000, 7, 0, 1'b0);

    // Abort a len=4 job after its first beat.
    bus.start = 1'b1; bus.start_len = 8'd4; bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort in_ready", 32'(bus.in_ready), 32'(1));
    bus.in_valid = 1'b1;
    bus.in_a0 = 4'b0010; bus.in_b0 = 4'b0010; bus.in_a1 = 4'b0010; bus.in_b1 = 4'b0010;
    @(negedge clk);
    bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort start_ready", 32'(bus.start_ready), 32'(1));
    check("abort busy", 32'(busy), 32'(0));
    check("abort in_ready low", 32'(bus.in_ready), 32'(0));
    check("abort mac_clr", 32'(mac_clr), 32'(1));
    check("abort res_valid", 32'(bus.res_valid), 32'(0));
    run_job("after abort", 1, 16'hFFFF, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
            4'b0010, 4'b0000, 7, 0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp4_mac_seq.md
# fp4_mac_seq

Job sequencer for the two-lane FP4 (E2M1) multiply-accumulate datapath. It accepts a dot-product job of LEN operand pairs per lane and clears the MAC accumulators. It streams operands into the MAC through a valid/ready input, drains the MAC pipeline with zero operands, captures both lane results, and holds them on a valid/ready result port. It sits between the operand buffers and the MAC instance; it is the only driver of the MAC operand and clear inputs.

## Interface
- LEN_W, 8: width of job length; max LEN = 2^LEN_W-1
- MAC_LAT, 3: cycles from an operand pair at the MAC inputs to its contribution appearing on facc0/facc1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  job request; taken when start_ready=1
- start_len  in  LEN_W  operand pairs per lane for the job
- start_ready  out  1  high only in IDLE
- in_valid  in  1  operand beat valid
- in_a0, in_b0, in_a1, in_b1  in  4 each  FP4 operands, lane 0 and lane 1
- in_ready  out  1  high only in RUN
- mac_a0, mac_b0, mac_a1, mac_b1  out  4 each  registered operands to MAC
- mac_clr  out  1  registered; drives MAC reset (clears accumulators and output regs)
- facc0, facc1  in  4 each  MAC lane results
- res_valid  out  1  result available
- res0, res1  out  4 each  captured lane results, stable while res_valid
- res_ready  in  1  result consumed when res_valid&res_ready
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: start_ready=1. On start: latch start_len into len_q, zero cnt, go to CLEAR.
- CLEAR: lasts exactly 1 cycle. The mac_clr register is 1 for the following cycle and operands are 0. Next state is RUN if len_q!=0, else DRAIN.
- RUN: in_ready=1. On each handshake, the mac_* registers load in_* and cnt increments. On a cycle with no handshake, mac_* load 4'b0000; a zero product leaves the accumulator unchanged. When the handshake makes cnt==len_q, go to DRAIN and clear cnt.
- DRAIN: mac_* = 0 for MAC_LAT+1 cycles, counted by cnt. The extra cycle covers the operand register. On the last DRAIN cycle, res0<=facc0, res1<=facc1 and state goes to DONE.
- DONE: res_valid=1. On res_ready, go to IDLE. res0/res1 hold until the next capture.
- start outside IDLE is ignored and is not queued. in_valid outside RUN is ignored. res_ready outside DONE is ignored.
- cnt width is max(LEN_W, clog2(MAC_LAT+2)). No wrap is possible because len_q is at most 2^LEN_W-1.
- No arithmetic is done in this block. Operands pass through bit-exact.

## Timing
- Reset values (when rst is sampled high): state IDLE, mac_clr=1, mac_*=0, res0=res1=0, res_valid=0, busy=0, cnt=0, len_q=0. start_ready=1 and in_ready=0 are combinational from state.
- mac_clr falls on the first edge after rst deasserts. It is also 1 for exactly the cycle after the CLEAR state.
- rst mid-job aborts immediately: no result, MAC cleared, no in_ready pulse.
- Start-to-first in_ready: 2 cycles (IDLE→CLEAR→RUN).
- Operand beat k (k=1..len_q) is seen by the MAC 1 cycle after its handshake.
- Job latency with in_valid held high is 2 + len_q + (MAC_LAT+1) cycles from the start edge to res_valid rising.
- res_valid rises 1 cycle after the capture edge. It falls on the edge where res_ready is sampled high.
- Back-to-back: start may be asserted the cycle after the result handshake; minimum IDLE dwell is 1 cycle.
- len_q=0: CLEAR→DRAIN; the result is 0000/0000.

## Test plan
- Reset, then single job, len=1, a0=b0=4'b0010 (1.0), a1=b1=0 → res0=4'b0010, res1=4'b0000, res_valid at cycle 2+1+MAC_LAT+1=7 after start.
- Job len=2, both beats a0=b0=a1=b1=4'b0010 → res0=res1=4'b0100 (2.0); exactly 2 in_ready handshakes consumed, third in_valid beat left pending.
- Job len=3 with in_valid gaps (valid pattern 1,0,0,1,0,1) → same result as the gapless run; latency extended by 3 cycles; mac_* = 0 on gap cycles.
- len=0 → no in_ready ever asserted; res0=res1=0000 after 2+MAC_LAT+1 cycles; start pulsed during DRAIN/DONE is ignored.
- res_ready held low for 10 cycles → res_valid, res0, res1 stable; handshake returns to IDLE; next start the following cycle shows mac_clr=1 for one cycle before new operands.
- rst asserted mid-RUN (after beat 1 of len=4) → next cycle IDLE, mac_clr=1, res_valid=0; a fresh len=1 job with 1.0×1.0 returns 0010, proving the accumulator was cleared.
